// File: rtl/fc_2nd_mac_if.sv
// Bus bundle for the FC2 output-neuron engine: activation handshake, weight ROM
// port and classifier results. The slave side is the engine. The master side is
// the surrounding fabric: the upstream producer, the weight ROM and the classifier.
interface fc_2nd_mac_if #(
   parameter int unsigned Bit_width = 16
);
   // Activation vector handshake
   logic                        in_valid;
   logic                        in_ready;
   logic signed [Bit_width-1:0] x_0;
   logic signed [Bit_width-1:0] x_1;
   logic signed [Bit_width-1:0] x_2;
   logic signed [Bit_width-1:0] x_3;
   logic signed [Bit_width-1:0] x_4;

   // Weight ROM port (w_0 is the shared bias)
   logic                        rom_en;
   logic [3:0]                  rom_addr;
   logic signed [Bit_width-1:0] w_0;
   logic signed [Bit_width-1:0] w_1;
   logic signed [Bit_width-1:0] w_2;
   logic signed [Bit_width-1:0] w_3;
   logic signed [Bit_width-1:0] w_4;
   logic signed [Bit_width-1:0] w_5;

   // Classifier results
   logic signed [Bit_width-1:0] y_0;
   logic signed [Bit_width-1:0] y_1;
   logic signed [Bit_width-1:0] y_2;
   logic signed [Bit_width-1:0] y_3;
   logic [1:0]                  class_idx;
   logic                        out_valid;
   logic                        busy;

   modport master (
      output in_valid, x_0, x_1, x_2, x_3, x_4,
      output w_0, w_1, w_2, w_3, w_4, w_5,
      input  in_ready, rom_en, rom_addr,
      input  y_0, y_1, y_2, y_3, class_idx, out_valid, busy
   );

   modport slave (
      input  in_valid, x_0, x_1, x_2, x_3, x_4,
      input  w_0, w_1, w_2, w_3, w_4, w_5,
      output in_ready, rom_en, rom_addr,
      output y_0, y_1, y_2, y_3, class_idx, out_valid, busy
   );
endinterface

// File: rtl/fc_2nd_mac.sv
// FC2 output-neuron engine. It takes one 5-element activation vector and runs
// each of the 4 neurons in turn: it fetches the bias and weights from the ROM,
// does a serial MAC, then rounds, adds the bias and saturates. It reports all
// results together with the argmax class.
module fc_2nd_mac #(
   parameter int unsigned Bit_width = 16
) (
   input  logic        CLK,
   input  logic        RST,
   fc_2nd_mac_if.slave bus
);

   localparam int unsigned NUM_IN    = 5;
   localparam int unsigned NUM_OUT   = 4;
   localparam int unsigned FRAC_BITS = 8;
   localparam int unsigned ACC_W     = 40;
   localparam int unsigned PROD_W    = 2 * Bit_width;

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC_BITS - 1));
   localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (Bit_width - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      MAC     = 3'd3,
      WRITE   = 3'd4,
      DONE    = 3'd5
   } state_e;

   state_e                      state_q;
   logic [1:0]                  n_q;
   logic [2:0]                  k_q;
   logic signed [ACC_W-1:0]     acc_q;
   logic signed [Bit_width-1:0] x_q    [NUM_IN];
   logic signed [Bit_width-1:0] wgt_q  [NUM_IN];
   logic signed [Bit_width-1:0] bias_q;
   logic signed [Bit_width-1:0] y_q    [NUM_OUT];
   logic signed [Bit_width-1:0] best_val_q;
   logic [1:0]                  best_idx_q;
   logic [1:0]                  class_idx_q;
   logic                        out_valid_q;
   logic                        in_ready_q;
   logic                        busy_q;
   logic                        rom_en_q;
   logic [3:0]                  rom_addr_q;

   logic signed [Bit_width-1:0] x_sel_c;
   logic signed [Bit_width-1:0] w_sel_c;
   logic signed [PROD_W-1:0]    prod_c;
   logic signed [ACC_W-1:0]     acc_d;
   logic signed [ACC_W-1:0]     rnd_c;
   logic signed [ACC_W-1:0]     sum_c;
   logic signed [Bit_width-1:0] y_d;
   logic                        best_upd_c;
   logic [1:0]                  best_idx_d;

   // Serial MAC datapath: one full-width product per cycle, sign-extended into the accumulator
   always_comb begin
      x_sel_c = x_q[k_q];
      w_sel_c = wgt_q[k_q];
      prod_c  = x_sel_c * w_sel_c;
      acc_d   = acc_q + ACC_W'(prod_c);
   end

   // Round half up, add bias at full accumulator width, saturate only the final value
   always_comb begin
      rnd_c = (acc_q + RND_HALF) >>> FRAC_BITS;
      sum_c = rnd_c + ACC_W'(bias_q);
      if (sum_c > SAT_MAX) begin
         y_d = Bit_width'(SAT_MAX);
      end else if (sum_c < SAT_MIN) begin
         y_d = Bit_width'(SAT_MIN);
      end else begin
         y_d = Bit_width'(sum_c);
      end
   end

   // Running argmax: neuron 0 seeds it, strict '>' keeps the lowest index on ties
   always_comb begin
      best_upd_c = (n_q == 2'd0) || (y_d > best_val_q);
      best_idx_d = best_upd_c ? n_q : best_idx_q;
   end

   // Control FSM with all outputs registered
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         n_q         <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         bias_q      <= '0;
         best_val_q  <= '0;
         best_idx_q  <= '0;
         class_idx_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         rom_en_q    <= 1'b0;
         rom_addr_q  <= '0;
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            x_q[i]   <= '0;
            wgt_q[i] <= '0;
         end
         for (int unsigned i = 0; i < NUM_OUT; i++) begin
            y_q[i] <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  x_q[0]     <= bus.x_0;
                  x_q[1]     <= bus.x_1;
                  x_q[2]     <= bus.x_2;
                  x_q[3]     <= bus.x_3;
                  x_q[4]     <= bus.x_4;
                  n_q        <= '0;
                  acc_q      <= '0;
                  best_val_q <= '0;
                  best_idx_q <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  rom_en_q   <= 1'b1;
                  rom_addr_q <= '0;
                  state_q    <= FETCH;
               end
            end
            FETCH: begin
               acc_q   <= '0;
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               // ROM data was refreshed on the FETCH negedge and is stable here
               bias_q   <= bus.w_0;
               wgt_q[0] <= bus.w_1;
               wgt_q[1] <= bus.w_2;
               wgt_q[2] <= bus.w_3;
               wgt_q[3] <= bus.w_4;
               wgt_q[4] <= bus.w_5;
               k_q      <= '0;
               rom_en_q <= 1'b0;
               state_q  <= MAC;
            end
            MAC: begin
               acc_q <= acc_d;
               if (k_q == 3'(NUM_IN - 1)) begin
                  k_q     <= '0;
                  state_q <= WRITE;
               end else begin
                  k_q <= k_q + 3'd1;
               end
            end
            WRITE: begin
               y_q[n_q]   <= y_d;
               best_idx_q <= best_idx_d;
               if (best_upd_c) begin
                  best_val_q <= y_d;
               end
               if (n_q == 2'(NUM_OUT - 1)) begin
                  class_idx_q <= best_idx_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  n_q        <= n_q + 2'd1;
                  acc_q      <= '0;
                  rom_en_q   <= 1'b1;
                  rom_addr_q <= 4'(n_q) + 4'd1;
                  state_q    <= FETCH;
               end
            end
            DONE: begin
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Drive the registered outputs onto the bus
   assign bus.in_ready  = in_ready_q;
   assign bus.rom_en    = rom_en_q;
   assign bus.rom_addr  = rom_addr_q;
   assign bus.y_0       = y_q[0];
   assign bus.y_1       = y_q[1];
   assign bus.y_2       = y_q[2];
   assign bus.y_3       = y_q[3];
   assign bus.class_idx = class_idx_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fc_2nd_mac.sv
// Directed bench for fc_2nd_mac with a behavioural FC2 weight ROM.
module tb_fc_2nd_mac;

   logic CLK;
   logic RST;

   fc_2nd_mac_if #(.Bit_width(16)) bus ();

   fc_2nd_mac #(.Bit_width(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ROM image: column 0 is the bias, columns 1..5 are the weights
   int rom [4][6];
   initial begin
      rom[0] = '{29, -316,  128, 10, -5, 1};
      rom[1] = '{29,  267,  -64, 20, -6, 2};
      rom[2] = '{29, -359,    0, 30, -7, 3};
      rom[3] = '{29, -297,  256, 40, -8, 4};
   end

   // ROM model: updates on negedge while enabled, outputs 0 otherwise
   always @(negedge CLK) begin
      if (bus.rom_en && bus.rom_addr < 4'd4) begin
         bus.w_0 <= 16'(rom[bus.rom_addr[1:0]][0]);
         bus.w_1 <= 16'(rom[bus.rom_addr[1:0]][1]);
         bus.w_2 <= 16'(rom[bus.rom_addr[1:0]][2]);
         bus.w_3 <= 16'(rom[bus.rom_addr[1:0]][3]);
         bus.w_4 <= 16'(rom[bus.rom_addr[1:0]][4]);
         bus.w_5 <= 16'(rom[bus.rom_addr[1:0]][5]);
      end else begin
         bus.w_0 <= '0;
         bus.w_1 <= '0;
         bus.w_2 <= '0;
         bus.w_3 <= '0;
         bus.w_4 <= '0;
         bus.w_5 <= '0;
      end
   end

   int checks = 0;
   int errors = 0;
   int vx [5];
   int vy [4];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_x(input int a, input int b, input int c, input int d, input int e);
      bus.x_0 = 16'(a);
      bus.x_1 = 16'(b);
      bus.x_2 = 16'(c);
      bus.x_3 = 16'(d);
      bus.x_4 = 16'(e);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(posedge CLK);
         #1;
         n++;
      end
      chk({tag, "_rdy"}, int'(bus.in_ready === 1'b1), 1);
   endtask

   // Run one vector from vx and check the result against vy and ecls
   task automatic run_vec(input string tag, input int ecls, input bit hold);
      int ov_cnt = 0;
      int ov_pos = -1;
      int ov_cls = -1;
      int rom_err = 0;
      bit exp_en;
      wait_ready(tag);
      drive_x(vx[0], vx[1], vx[2], vx[3], vx[4]);
      bus.in_valid = 1'b1;
      @(posedge CLK);
      #1;
      for (int c = 0; c < 34; c++) begin
         if (hold && c < 32) begin
            bus.in_valid = 1'b1;
            drive_x(c * 37 + 1, -c, 1000, c, 7);
         end else begin
            bus.in_valid = 1'b0;
         end
         if (c == 0) begin
            chk({tag, "_acc_rdy"}, int'(bus.in_ready), 0);
            chk({tag, "_busy"}, int'(bus.busy), 1);
         end
         exp_en = (c < 32) && ((c % 8) < 2);
         if (bus.rom_en !== exp_en) rom_err++;
         if (exp_en && bus.rom_addr !== 4'(c / 8)) rom_err++;
         if (bus.out_valid === 1'b1) begin
            ov_cnt++;
            ov_pos = c;
            ov_cls = int'(bus.class_idx);
         end
         if (c < 33) begin
            @(posedge CLK);
            #1;
         end
      end
      chk({tag, "_romseq"}, rom_err, 0);
      chk({tag, "_ovcnt"}, ov_cnt, 1);
      chk({tag, "_ovpos"}, ov_pos, 32);
      chk({tag, "_ovcls"}, ov_cls, ecls);
      chk({tag, "_y0"}, int'(bus.y_0), vy[0]);
      chk({tag, "_y1"}, int'(bus.y_1), vy[1]);
      chk({tag, "_y2"}, int'(bus.y_2), vy[2]);
      chk({tag, "_y3"}, int'(bus.y_3), vy[3]);
      chk({tag, "_cls"}, int'(bus.class_idx), ecls);
      chk({tag, "_idle_rdy"}, int'(bus.in_ready), 1);
      chk({tag, "_idle_busy"}, int'(bus.busy), 0);
   endtask

   // Start x=(256,0,0,0,0), pulse reset during MAC of neuron 2, confirm a clean abort
   task automatic run_abort();
      int ov_cnt = 0;
      wait_ready("abort");
      drive_x(256, 0, 0, 0, 0);
      bus.in_valid = 1'b1;
      @(posedge CLK);
      #1;
      bus.in_valid = 1'b0;
      for (int c = 0; c < 19; c++) begin
         if (bus.out_valid === 1'b1) ov_cnt++;
         @(posedge CLK);
         #1;
      end
      chk("abort_pre_y1", int'(bus.y_1), 296);
      chk("abort_pre_busy", int'(bus.busy), 1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("abort_rdy", int'(bus.in_ready), 1);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_y0", int'(bus.y_0), 0);
      chk("abort_y1", int'(bus.y_1), 0);
      chk("abort_rom_en", int'(bus.rom_en), 0);
      chk("abort_cls", int'(bus.class_idx), 0);
      for (int c = 0; c < 40; c++) begin
         if (bus.out_valid === 1'b1) ov_cnt++;
         @(posedge CLK);
         #1;
      end
      chk("abort_no_ov", ov_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b1;
      bus.in_valid = 1'b0;
      drive_x(0, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_y0", int'(bus.y_0), 0);
      chk("rst_y1", int'(bus.y_1), 0);
      chk("rst_y2", int'(bus.y_2), 0);
      chk("rst_y3", int'(bus.y_3), 0);
      chk("rst_cls", int'(bus.class_idx), 0);
      chk("rst_ov", int'(bus.out_valid), 0);
      chk("rst_rom_en", int'(bus.rom_en), 0);
      chk("rst_rom_addr", int'(bus.rom_addr), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_rdy", int'(bus.in_ready), 1);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      vx = '{0, 0, 0, 0, 0};          vy = '{29, 29, 29, 29};
      run_vec("zero", 0, 1'b0);
      vx = '{256, 0, 0, 0, 0};        vy = '{-287, 296, -330, -268};
      run_vec("unit", 1, 1'b0);
      vx = '{1, 0, 0, 0, 0};          vy = '{28, 30, 28, 28};
      run_vec("round", 1, 1'b0);
      vx = '{32767, 0, 0, 0, 0};      vy = '{-32768, 32767, -32768, -32768};
      run_vec("sat", 1, 1'b0);
      vx = '{0, 512, 0, 0, 0};        vy = '{285, -99, 29, 541};
      run_vec("x1", 3, 1'b0);
      vx = '{256, 512, 256, 256, 256}; vy = '{-25, 184, -304, 280};
      run_vec("full", 3, 1'b0);
      vx = '{0, 0, 0, 0, -128};       vy = '{29, 28, 28, 27};
      run_vec("halfneg", 0, 1'b0);
      vx = '{256, 0, 0, 0, 0};        vy = '{-287, 296, -330, -268};
      run_vec("hold", 1, 1'b1);
      run_abort();
      vx = '{256, 512, 256, 256, 256}; vy = '{-25, 184, -304, 280};
      run_vec("post_abort", 3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
